// File: rtl/arm_mem_responder_pkg.sv
// Shared definitions for the ARM memory responder and its byte-stream loader.
// Holds the loader state encoding, mem_err bit positions and alignment shifts.
package arm_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_DONE    = 2'd2
    } load_state_t;

    localparam int ERR_DATA  = 0;
    localparam int ERR_FETCH = 1;
    localparam int ERR_LOAD  = 2;

    localparam int IMEM_SHIFT = 2;
    localparam int DMEM_SHIFT = 3;

    // True when addr is aligned to (1 << shift) bytes and its word index is below words.
    function automatic logic addr_ok(input logic [63:0] addr, input int shift, input int words);
        logic [63:0] mask;
        mask = (64'd1 << shift) - 64'd1;
        return ((addr & mask) == 64'd0) && ((addr >> shift) < 64'(words));
    endfunction

endpackage

// File: rtl/arm_mem_loader.sv
// Byte-stream loader: assembles little-endian bytes into 32/64-bit words and
// emits one write per completed (or final, zero-padded) word.
module arm_mem_loader
    import arm_mem_responder_pkg::*;
#(
    parameter int LEN_W       = 16,
    parameter int IMEM_WORDS  = 256,
    parameter int DMEM_DWORDS = 256
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             load_start,
    input  logic             load_sel,
    input  logic [LEN_W-1:0] load_len,
    input  logic             load_valid,
    input  logic [7:0]       load_byte,
    output logic             load_ready,
    output logic             load_done,
    output logic             cpu_hold,
    output logic             loading,
    output logic             wr_en,
    output logic             wr_sel,
    output logic [LEN_W-1:0] wr_index,
    output logic [63:0]      wr_data,
    output logic             overflow
);

    load_state_t      state_reg, state_next;
    logic [LEN_W-1:0] count_reg, count_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic             sel_reg, sel_next;
    logic [63:0]      buf_reg, buf_next;

    logic [2:0]       lane;
    logic             lane_last;
    logic [LEN_W:0]   count_inc;
    logic             final_byte;
    logic             last_byte;
    logic [LEN_W-1:0] word_index;
    logic             in_range;
    logic [63:0]      assembled;

    assign lane       = sel_reg ? count_reg[2:0] : {1'b0, count_reg[1:0]};
    assign lane_last  = sel_reg ? (count_reg[2:0] == 3'd7) : (count_reg[1:0] == 2'd3);
    assign count_inc  = {1'b0, count_reg} + (LEN_W+1)'(1);
    assign final_byte = (count_inc == {1'b0, len_reg});
    assign last_byte  = lane_last || final_byte;
    assign word_index = sel_reg ? (count_reg >> DMEM_SHIFT) : (count_reg >> IMEM_SHIFT);
    assign in_range   = sel_reg ? (32'(word_index) < 32'(DMEM_DWORDS))
                                : (32'(word_index) < 32'(IMEM_WORDS));

    // Lanes above the current one come from a buffer that is cleared after every
    // commit, which gives the zero padding of a short final word for free.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign assembled[gi*8 +: 8] = (lane == 3'(gi)) ? load_byte : buf_reg[gi*8 +: 8];
        end
    endgenerate

    assign wr_sel   = sel_reg;
    assign wr_index = word_index;
    assign wr_data  = assembled;
    assign loading  = (state_reg == ST_LOADING);

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            len_reg   <= '0;
            sel_reg   <= 1'b0;
            buf_reg   <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            len_reg   <= len_next;
            sel_reg   <= sel_next;
            buf_reg   <= buf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        len_next   = len_reg;
        sel_next   = sel_reg;
        buf_next   = buf_reg;
        load_ready = 1'b0;
        load_done  = 1'b0;
        cpu_hold   = 1'b0;
        wr_en      = 1'b0;
        overflow   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (load_start) begin
                    sel_next   = load_sel;
                    len_next   = load_len;
                    count_next = '0;
                    buf_next   = '0;
                    state_next = (load_len == '0) ? ST_DONE : ST_LOADING;
                end
            end
            ST_LOADING: begin
                cpu_hold   = 1'b1;
                load_ready = 1'b1;
                if (load_valid) begin
                    count_next = count_inc[LEN_W-1:0];
                    buf_next   = last_byte ? 64'd0 : assembled;
                    if (in_range) begin
                        wr_en = last_byte;
                    end else begin
                        overflow = 1'b1;
                    end
                    if (final_byte) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                cpu_hold   = 1'b1;
                load_done  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/arm_mem_responder.sv
// Memory-side responder for the pipelined ARM CPU: instruction and data arrays
// with combinational reads, CPU stores, a preload path and sticky error flags.
module arm_mem_responder
    import arm_mem_responder_pkg::*;
#(
    parameter int IMEM_WORDS  = 256,
    parameter int DMEM_DWORDS = 256,
    parameter int LEN_W       = 16
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [63:0]      PC,
    output logic [31:0]      IC,
    input  logic [63:0]      mem_address_in,
    input  logic [63:0]      mem_data_in,
    input  logic             control_memwrite_in,
    input  logic             control_memread_in,
    output logic [63:0]      mem_data_out,
    input  logic             load_start,
    input  logic             load_sel,
    input  logic [LEN_W-1:0] load_len,
    input  logic             load_valid,
    input  logic [7:0]       load_byte,
    output logic             load_ready,
    output logic             load_done,
    output logic             cpu_hold,
    output logic [2:0]       mem_err
);

    localparam int IA_W = $clog2(IMEM_WORDS);
    localparam int DA_W = $clog2(DMEM_DWORDS);

    logic [31:0] imem [IMEM_WORDS];
    logic [63:0] dmem [DMEM_DWORDS];

    logic             loading;
    logic             ld_wr_en;
    logic             ld_wr_sel;
    logic [LEN_W-1:0] ld_wr_index;
    logic [63:0]      ld_wr_data;
    logic             ld_overflow;

    logic            fetch_ok;
    logic            data_ok;
    logic [IA_W-1:0] fetch_idx;
    logic [DA_W-1:0] data_idx;
    logic            cpu_wr;
    logic            ld_imem_wr;
    logic            ld_dmem_wr;
    logic [2:0]      err_reg, err_next;

    arm_mem_loader #(
        .LEN_W       (LEN_W),
        .IMEM_WORDS  (IMEM_WORDS),
        .DMEM_DWORDS (DMEM_DWORDS)
    ) u_loader (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .load_start (load_start),
        .load_sel   (load_sel),
        .load_len   (load_len),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .load_ready (load_ready),
        .load_done  (load_done),
        .cpu_hold   (cpu_hold),
        .loading    (loading),
        .wr_en      (ld_wr_en),
        .wr_sel     (ld_wr_sel),
        .wr_index   (ld_wr_index),
        .wr_data    (ld_wr_data),
        .overflow   (ld_overflow)
    );

    assign fetch_ok  = addr_ok(PC, IMEM_SHIFT, IMEM_WORDS);
    assign data_ok   = addr_ok(mem_address_in, DMEM_SHIFT, DMEM_DWORDS);
    assign fetch_idx = PC[IA_W+IMEM_SHIFT-1:IMEM_SHIFT];
    assign data_idx  = mem_address_in[DA_W+DMEM_SHIFT-1:DMEM_SHIFT];

    assign IC           = (fetch_ok && !loading) ? imem[fetch_idx] : 32'd0;
    assign mem_data_out = (control_memread_in && data_ok) ? dmem[data_idx] : 64'd0;

    // No array writes on a reset edge, so an interrupted load cannot leak a word.
    assign cpu_wr     = RESET && control_memwrite_in && data_ok && !cpu_hold;
    assign ld_imem_wr = RESET && ld_wr_en && !ld_wr_sel && (32'(ld_wr_index) < 32'(IMEM_WORDS));
    assign ld_dmem_wr = RESET && ld_wr_en &&  ld_wr_sel && (32'(ld_wr_index) < 32'(DMEM_DWORDS));

    always_ff @(posedge CLOCK) begin
        if (ld_imem_wr) begin
            imem[ld_wr_index[IA_W-1:0]] <= ld_wr_data[31:0];
        end
    end

    always_ff @(posedge CLOCK) begin
        if (ld_dmem_wr) begin
            dmem[ld_wr_index[DA_W-1:0]] <= ld_wr_data;
        end else if (cpu_wr) begin
            dmem[data_idx] <= mem_data_in;
        end
    end

    always_comb begin
        err_next = err_reg;
        if ((control_memread_in || control_memwrite_in) && !data_ok) begin
            err_next[ERR_DATA] = 1'b1;
        end
        if (!fetch_ok && !loading) begin
            err_next[ERR_FETCH] = 1'b1;
        end
        if (ld_overflow) begin
            err_next[ERR_LOAD] = 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            err_reg <= 3'b000;
        end else begin
            err_reg <= err_next;
        end
    end

    assign mem_err = err_reg;

endmodule

// File: tb/tb_arm_mem_responder.sv
// Self-checking bench: directed scenarios plus randomized CPU traffic and loads,
// compared every cycle against a queue/array model of the responder.
module tb_arm_mem_responder;

    localparam int IW = 256;
    localparam int DW = 256;
    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_DONE = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] pc, addr, wdata, rdata;
    logic [31:0] ic;
    logic        memwrite, memread;
    logic        ld_start, ld_sel, ld_valid, ld_ready, ld_done, hold;
    logic [15:0] ld_len;
    logic [7:0]  ld_byte;
    logic [2:0]  err;

    logic [63:0] s_pc, s_addr, s_wdata, s_rdata;
    logic [31:0] s_ic;
    logic        s_memwrite, s_memread;
    logic        s_start, s_sel, s_valid, s_ready, s_done, s_hold;
    logic [15:0] s_len;
    logic [7:0]  s_byte;
    logic [2:0]  s_err;

    always #5 clk = ~clk;

    arm_mem_responder #(.IMEM_WORDS(IW), .DMEM_DWORDS(DW), .LEN_W(16)) dut (
        .CLOCK(clk), .RESET(rst_n), .PC(pc), .IC(ic),
        .mem_address_in(addr), .mem_data_in(wdata),
        .control_memwrite_in(memwrite), .control_memread_in(memread),
        .mem_data_out(rdata), .load_start(ld_start), .load_sel(ld_sel),
        .load_len(ld_len), .load_valid(ld_valid), .load_byte(ld_byte),
        .load_ready(ld_ready), .load_done(ld_done), .cpu_hold(hold), .mem_err(err)
    );

    arm_mem_responder #(.IMEM_WORDS(4), .DMEM_DWORDS(4), .LEN_W(16)) dut_small (
        .CLOCK(clk), .RESET(rst_n), .PC(s_pc), .IC(s_ic),
        .mem_address_in(s_addr), .mem_data_in(s_wdata),
        .control_memwrite_in(s_memwrite), .control_memread_in(s_memread),
        .mem_data_out(s_rdata), .load_start(s_start), .load_sel(s_sel),
        .load_len(s_len), .load_valid(s_valid), .load_byte(s_byte),
        .load_ready(s_ready), .load_done(s_done), .cpu_hold(s_hold), .mem_err(s_err)
    );

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int s_done_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0]  m_imem [IW];
    bit           m_ik   [IW];
    logic [63:0]  m_dmem [DW];
    bit           m_dk   [DW];
    int           m_phase = P_IDLE;
    int           m_cnt = 0;
    int           m_len = 0;
    bit           m_sel = 1'b0;
    logic [7:0]   m_cur [$];
    logic [2:0]   m_err = 3'b000;
    bit           live = 1'b0;

    function automatic bit fetch_ok(input logic [63:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < 64'(IW));
    endfunction

    function automatic bit data_ok(input logic [63:0] a);
        return (a[2:0] == 3'b000) && ((a >> 3) < 64'(DW));
    endfunction

    function automatic void model_accept(input logic [7:0] b);
        int lanes;
        int cap;
        int widx;
        logic [63:0] w;
        lanes = m_sel ? 8 : 4;
        cap   = m_sel ? DW : IW;
        widx  = m_cnt / lanes;
        if (widx >= cap) m_err[2] = 1'b1;
        m_cur.push_back(b);
        m_cnt++;
        if (m_cur.size() == lanes || m_cnt == m_len) begin
            if (widx < cap) begin
                w = 64'd0;
                foreach (m_cur[i]) w = w | (64'(m_cur[i]) << (8 * i));
                if (m_sel) begin
                    m_dmem[widx] = w;
                    m_dk[widx] = 1'b1;
                end else begin
                    m_imem[widx] = w[31:0];
                    m_ik[widx] = 1'b1;
                end
            end
            m_cur.delete();
        end
        if (m_cnt == m_len) m_phase = P_DONE;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = P_IDLE;
            m_cnt = 0;
            m_cur.delete();
            m_err = 3'b000;
            live = 1'b1;
        end else begin
            if (m_phase != P_LOAD && !fetch_ok(pc)) m_err[1] = 1'b1;
            if ((memread || memwrite) && !data_ok(addr)) m_err[0] = 1'b1;
            if (memwrite && data_ok(addr) && m_phase == P_IDLE) begin
                m_dmem[addr[10:3]] = wdata;
                m_dk[addr[10:3]] = 1'b1;
            end
            case (m_phase)
                P_IDLE: if (ld_start) begin
                    m_sel = ld_sel;
                    m_len = int'(ld_len);
                    m_cnt = 0;
                    m_cur.delete();
                    m_phase = (m_len == 0) ? P_DONE : P_LOAD;
                end
                P_LOAD: if (ld_valid) model_accept(ld_byte);
                default: m_phase = P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("cpu_hold", hold, 64'(m_phase != P_IDLE));
            check("load_ready", ld_ready, 64'(m_phase == P_LOAD));
            check("load_done", ld_done, 64'(m_phase == P_DONE));
            check("mem_err", err, m_err);
            if (ld_done) done_seen++;
            if (m_phase != P_LOAD && fetch_ok(pc)) begin
                if (m_ik[pc[9:2]]) check("ic", ic, m_imem[pc[9:2]]);
            end else begin
                check("ic_zero", ic, 64'd0);
            end
            if (memread && data_ok(addr)) begin
                if (m_dk[addr[10:3]]) check("rdata", rdata, m_dmem[addr[10:3]]);
            end else begin
                check("rdata_zero", rdata, 64'd0);
            end
        end
        if (s_done) s_done_seen++;
    end

    // ---------------- stimulus ----------------
    logic [7:0] stream [$];

    task automatic main_load(input bit sel, input int len, input int n_feed, input bit wiggle);
        logic [63:0] saved;
        ld_sel = sel;
        ld_len = 16'(len);
        ld_start = 1'b1;
        tick;
        ld_start = 1'b0;
        saved = pc;
        if (wiggle) pc = 64'h2;
        for (int i = 0; i < n_feed; i++) begin
            if (wiggle && i == n_feed - 1) pc = saved;
            repeat ($urandom_range(0, 2)) begin
                ld_valid = 1'b0;
                ld_start = 1'($urandom_range(0, 1));
                ld_len = 16'($urandom);
                tick;
            end
            ld_start = 1'b0;
            ld_valid = 1'b1;
            ld_byte = stream[i];
            tick;
            ld_valid = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int d0;
        int len;
        bit sel;
        logic [7:0] sb [20];
        logic [63:0] bad;

        rst_n = 1'b0; pc = 0; addr = 0; wdata = 0; memwrite = 0; memread = 0;
        ld_start = 0; ld_sel = 0; ld_len = 0; ld_valid = 0; ld_byte = 0;
        s_pc = 0; s_addr = 0; s_wdata = 0; s_memwrite = 0; s_memread = 0;
        s_start = 0; s_sel = 0; s_len = 0; s_valid = 0; s_byte = 0;
        tick;
        tick;
        @(negedge clk);
        check("rst_hold", hold, 0);
        check("rst_ready", ld_ready, 0);
        check("rst_done", ld_done, 0);
        check("rst_err", err, 0);
        tick;
        rst_n = 1'b1;

        // 1: instruction preload, PC misaligned during the stream must not flag
        stream = '{8'h20, 8'h00, 8'h80, 8'hD2, 8'h41, 8'h00, 8'h00, 8'h8B};
        d0 = done_seen;
        main_load(1'b0, 8, 8, 1'b1);
        @(negedge clk);
        check("t1_done", ld_done, 1);
        tick;
        pc = 64'h0;
        @(negedge clk);
        check("t1_ic0", ic, 32'hD2800020);
        check("t1_hold", hold, 0);
        tick;
        pc = 64'h4;
        @(negedge clk);
        check("t1_ic4", ic, 32'h8B000041);
        check("t1_err", err, 0);
        tick;
        check("t1_done_count", 64'(done_seen - d0), 1);
        pc = 64'h0;

        // 2: store, read-back, and same-edge read/write
        addr = 64'h10; wdata = 64'h1122334455667788; memwrite = 1;
        tick;
        memwrite = 0; memread = 1;
        @(negedge clk);
        check("t2_readback", rdata, 64'h1122334455667788);
        tick;
        wdata = 64'hCAFEF00DDEADBEEF; memwrite = 1;
        @(negedge clk);
        check("t2_same_edge_old", rdata, 64'h1122334455667788);
        tick;
        memwrite = 0;
        @(negedge clk);
        check("t2_new", rdata, 64'hCAFEF00DDEADBEEF);
        tick;

        // 3: misaligned store dropped; misaligned fetch
        memread = 0; addr = 64'h13; wdata = 64'hFFFF_FFFF_FFFF_FFFF; memwrite = 1;
        tick;
        memwrite = 0; addr = 64'h10; memread = 1;
        @(negedge clk);
        check("t3_err_data", err, 3'b001);
        check("t3_unchanged", rdata, 64'hCAFEF00DDEADBEEF);
        tick;
        memread = 0; pc = 64'h2;
        @(negedge clk);
        check("t3_ic_mis", ic, 0);
        tick;
        pc = 64'h0;
        @(negedge clk);
        check("t3_err_both", err, 3'b011);

        // 4: short data load with zero padding, then zero-length load
        stream = '{8'hAA, 8'hBB, 8'hCC};
        main_load(1'b1, 3, 3, 1'b0);
        tick;
        addr = 64'h0; memread = 1;
        @(negedge clk);
        check("t4_dmem0", rdata, 64'h0000000000CCBBAA);
        tick;
        memread = 0; ld_sel = 1; ld_len = 0; ld_start = 1;
        tick;
        ld_start = 0; memread = 1;
        @(negedge clk);
        check("t4_len0_done", ld_done, 1);
        check("t4_len0_nowrite", rdata, 64'h0000000000CCBBAA);
        tick;
        memread = 0;
        tick;

        // 5: reset after 5 of 8 bytes
        stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        d0 = done_seen;
        main_load(1'b0, 8, 5, 1'b0);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_hold", hold, 0);
        check("t5_ready", ld_ready, 0);
        check("t5_err", err, 0);
        tick;
        pc = 64'h0;
        @(negedge clk);
        check("t5_ic0", ic, 32'h44332211);
        tick;
        pc = 64'h4;
        @(negedge clk);
        check("t5_ic1_kept", ic, 32'h8B000041);
        tick;
        check("t5_no_done", 64'(done_seen - d0), 0);

        // randomized traffic and loads
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                memwrite = 0; memread = 0;
                sel = 1'($urandom_range(0, 1));
                len = $urandom_range(0, 40);
                stream.delete();
                for (int j = 0; j < len; j++) stream.push_back(8'($urandom));
                main_load(sel, len, len, 1'b0);
                tick;
                tick;
            end else begin
                if ($urandom_range(0, 9) == 0) begin
                    case ($urandom_range(0, 2))
                        0: bad = 64'h3FC;
                        1: bad = 64'h400;
                        default: bad = {$urandom, $urandom};
                    endcase
                    pc = bad;
                end else begin
                    pc = 64'($urandom_range(0, 15)) * 64'd4;
                end
                if ($urandom_range(0, 9) == 0) begin
                    case ($urandom_range(0, 2))
                        0: bad = 64'h7F8;
                        1: bad = 64'h800;
                        default: bad = {$urandom, $urandom};
                    endcase
                    addr = bad;
                end else begin
                    addr = 64'($urandom_range(0, 15)) * 64'd8;
                end
                memread = 1'($urandom_range(0, 1));
                memwrite = ($urandom_range(0, 3) == 0);
                wdata = {$urandom, $urandom};
                tick;
            end
        end
        memread = 0; memwrite = 0; pc = 64'h0; addr = 64'h0;
        tick;

        // 6: overflow on a 4-word instruction memory
        for (int i = 0; i < 20; i++) sb[i] = 8'($urandom);
        s_sel = 0; s_len = 16'd20; s_start = 1;
        tick;
        s_start = 0;
        for (int i = 0; i < 20; i++) begin
            s_valid = 1; s_byte = sb[i];
            tick;
            if (i == 15) begin
                @(negedge clk);
                check("t6_err_before", s_err, 0);
                check("t6_no_early_done", s_done, 0);
            end
        end
        s_valid = 0;
        @(negedge clk);
        check("t6_done", s_done, 1);
        check("t6_err_ovf", s_err, 3'b100);
        tick;
        for (int k = 0; k < 4; k++) begin
            s_pc = 64'(k * 4);
            @(negedge clk);
            check("t6_ic", s_ic, {sb[4*k+3], sb[4*k+2], sb[4*k+1], sb[4*k]});
            tick;
        end
        s_pc = 64'd16;
        @(negedge clk);
        check("t6_ic_oor", s_ic, 0);
        tick;
        s_pc = 64'd0;
        @(negedge clk);
        check("t6_err_fetch", s_err, 3'b110);
        check("t6_done_count", 64'(s_done_seen), 1);
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arm_mem_responder.md
Name: arm_mem_responder

Overview:
- Memory-side responder for the pipelined ARM CPU. It serves the instruction-fetch port (PC in, IC out) and the data port (address, write data, memread/memwrite in, read data out).
- Holds an instruction memory of 32-bit words and a data memory of 64-bit doublewords.
- Includes a byte-stream loader FSM that preloads either memory while the CPU is held off via cpu_hold.
- Sits at top level beside the CPU in the SoC and testbench.

Parameters:
- IMEM_WORDS, 256, number of 32-bit instruction words; power of 2.
- DMEM_DWORDS, 256, number of 64-bit data doublewords; power of 2.
- LEN_W, 16, width of the loader byte-length field.

Ports:
- CLOCK  in  1  sole clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-low reset.
- PC  in  64  fetch byte address.
- IC  out  32  instruction at PC; combinational.
- mem_address_in  in  64  data byte address from the CPU.
- mem_data_in  in  64  store data from the CPU.
- control_memwrite_in  in  1  store request.
- control_memread_in  in  1  load request.
- mem_data_out  out  64  load data to the CPU; combinational.
- load_start  in  1  one-cycle pulse, sampled in IDLE only.
- load_sel  in  1  0 = instruction memory, 1 = data memory; latched at start.
- load_len  in  LEN_W  byte count, latched at start.
- load_valid  in  1  load_byte is valid.
- load_byte  in  8  stream byte, little-endian, starting at address 0.
- load_ready  out  1  responder accepts a byte.
- load_done  out  1  one-cycle completion pulse.
- cpu_hold  out  1  CPU must hold in reset while high.
- mem_err  out  3  sticky flags: [0] data misaligned or out of range, [1] fetch misaligned or out of range, [2] load overflow.

Behaviour:
- Reset (RESET=0 at an edge):
  - state=IDLE; load_ready=0, load_done=0, cpu_hold=0, mem_err=0.
  - Byte counter and assembly buffer cleared.
  - Memory contents are not cleared.
- Reset mid-load: aborts the load. Words already committed remain; the partial assembly buffer is discarded; no load_done pulse.
- Fetch, combinational:
  - IC = imem[PC>>2] when PC[1:0]==0, PC>>2 < IMEM_WORDS and state != LOADING.
  - Otherwise IC = 0.
  - mem_err[1] is set at the next edge on a misaligned or out-of-range PC, but not while LOADING.
- Data read, combinational:
  - mem_data_out = dmem[addr>>3] when memread=1, addr[2:0]==0 and in range.
  - Otherwise mem_data_out = 0.
- Data write:
  - Written at the rising edge when memwrite=1, aligned, in range and state != LOADING.
  - Misaligned or out-of-range access (read or write) sets mem_err[0]; a write in that case is dropped.
  - memread and memwrite both high is legal.
- Same-edge read/write to the same doubleword: the read returns the pre-edge contents; the new value is visible from the next cycle.
- FSM IDLE -> LOADING -> DONE -> IDLE:
  - IDLE: on load_start=1, latch load_sel and load_len and clear the counter.
    - If load_len==0, go to DONE.
    - Otherwise go to LOADING.
  - LOADING: cpu_hold=1 and load_ready=1.
    - A byte is accepted at an edge with load_valid && load_ready.
    - It is placed in lane count mod 4 (imem) or count mod 8 (dmem), and the counter increments.
    - A word is committed on the edge its last lane, or the final stream byte, is accepted; unfilled upper lanes are written as 0.
    - When the counter reaches load_len, go to DONE.
  - DONE: load_done=1 and cpu_hold=1 for exactly one cycle, then IDLE.
- Bytes addressed beyond the selected memory's capacity are discarded and set mem_err[2]; the load still runs to load_len.
- CPU data writes are ignored while LOADING or DONE.
- load_start is ignored outside IDLE.
- mem_err bits clear only on reset.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, LOADING=2'd1, DONE=2'd2.
  - mem_err bit indices.
  - Address-alignment shift constants: 2 for imem, 3 for dmem.
- One natural sub-module, arm_mem_loader: the FSM, counter and lane assembly. It emits a write strobe, word index, data and target select.
- The top level holds both arrays and the CPU-facing ports.

Test Plan:
1. Reset, then load_start with sel=0, len=8, bytes 20,00,80,D2,41,00,00,8B -> load_ready=1 for 8 accepts; load_done pulses once; then PC=0 gives IC=0xD2800020 and PC=4 gives IC=0x8B000041; cpu_hold low afterwards.
2. Store: memwrite=1, addr=0x10, data=0x1122334455667788 -> one cycle later memread at 0x10 returns 0x1122334455667788; a same-cycle read at 0x10 during the write returns the old value.
3. Misaligned store at addr=0x13 -> dmem unchanged; mem_err=3'b001; PC=0x2 gives IC=0 and mem_err=3'b011.
4. sel=1, len=3, bytes AA,BB,CC -> dmem[0]=0x0000000000CCBBAA; load_len=0 gives load_done one cycle after start with no writes.
5. RESET low after 5 of 8 bytes -> imem[0] holds the first word, imem[1] is unchanged; cpu_hold=0, load_ready=0, no load_done.
6. IMEM_WORDS=4, sel=0, len=20 -> 16 bytes stored; mem_err[2]=1; load_done pulses after the 20th byte.
